// File: rtl/x25519_stream_if_if.sv
// Word-stream bundle for the X25519 front/back end: 32-bit input words in,
// 32-bit result words out, each with its own ready/valid handshake.
interface x25519_stream_if_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/x25519_stream_if.sv
// Loads scalar and u-coordinate word-serially, pulses the core reset, times the
// core until valid (or timeout), then streams the 256-bit result out as 8 words.
module x25519_stream_if #(
   parameter logic [31:0] TIMEOUT = 32'd4_000_000
) (
   input  logic                clk,
   input  logic                rst,
   x25519_stream_if_if.slave   s,
   output logic                busy,
   output logic                timeout,
   output logic [31:0]         cycles,
   output logic                core_rst,
   output logic [255:0]        core_scalar,
   output logic [255:0]        core_point,
   input  logic [255:0]        core_point_out,
   input  logic                core_valid
);

   typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;

   state_t        state, state_nx;
   logic [3:0]    k;
   logic [2:0]    j;
   logic [255:0]  result;
   logic          in_fire, out_fire, run_abort;
   logic          in_ready_c, out_valid_c, busy_c;
   logic [7:0]    in_hi, out_hi;

   assign in_fire  = s.in_valid  && (state == LOAD);
   assign out_fire = s.out_ready && (state == DRAIN);

   // Abort on the cycle that would bring cycles up to TIMEOUT; 33-bit compare
   // keeps TIMEOUT=0 or max from wrapping.
   assign run_abort = (state == RUN) && !core_valid &&
                      (({1'b0, cycles} + 33'd1) >= {1'b0, TIMEOUT});

   // Word k lands MSB-first: k[2:0] picks the 32-bit lane within each operand.
   assign in_hi  = 8'd255 - {k[2:0], 5'd0};
   assign out_hi = 8'd255 - {j, 5'd0};

   always_comb begin
      state_nx    = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      case (state)
         LOAD: begin
            in_ready_c = 1'b1;
            if (in_fire && k == 4'd15) state_nx = START;
         end
         START: begin
            busy_c   = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            busy_c = 1'b1;
            if (core_valid || run_abort) state_nx = DRAIN;
         end
         DRAIN: begin
            busy_c      = 1'b1;
            out_valid_c = 1'b1;
            if (out_fire && j == 3'd7) state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k           <= 4'd0;
         j           <= 3'd0;
         result      <= '0;
         cycles      <= 32'd0;
         timeout     <= 1'b0;
         core_scalar <= '0;
         core_point  <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_fire) begin
                  if (!k[3]) core_scalar[in_hi -: 32] <= s.in_data;
                  else       core_point[in_hi -: 32]  <= s.in_data;
                  k <= k + 4'd1;
                  // Status is cleared on entry so it reads zero during START.
                  if (k == 4'd15) begin
                     cycles  <= 32'd0;
                     timeout <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (core_valid) begin
                  result <= core_point_out;
               end else if (run_abort) begin
                  result  <= '0;
                  timeout <= 1'b1;
                  cycles  <= TIMEOUT;
               end else begin
                  cycles <= cycles + 32'd1;
               end
            end
            DRAIN: begin
               if (out_fire) j <= j + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign s.in_ready  = in_ready_c;
   assign s.out_valid = out_valid_c;
   assign s.out_data  = (state == DRAIN) ? result[out_hi -: 32] : 32'd0;
   assign s.out_last  = (state == DRAIN) && (j == 3'd7);
   assign busy        = busy_c;
   // The START cycle masks any valid left high by the previous operation.
   assign core_rst    = rst || (state == START);

endmodule

// File: tb/tb_x25519_stream_if.sv
// Scoreboard bench: stimulus pushes expected words/status, a monitor pops and
// compares on every output handshake; a behavioural core answers after a delay.
module tb_x25519_stream_if;
   localparam logic [31:0] TMO = 32'd120;

   logic         clk, rst;
   logic         busy, timeout, core_rst, core_valid;
   logic [31:0]  cycles;
   logic [255:0] core_scalar, core_point, core_point_out;

   x25519_stream_if_if bus();

   x25519_stream_if #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .s(bus),
      .busy(busy), .timeout(timeout), .cycles(cycles),
      .core_rst(core_rst), .core_scalar(core_scalar), .core_point(core_point),
      .core_point_out(core_point_out), .core_valid(core_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural core: valid rises after m_delay non-reset cycles and stays
   // high until the next core reset.
   logic [255:0] m_res;
   int           m_delay;
   bit           m_never;
   int           m_cnt;
   logic         m_valid;
   assign core_point_out = m_res;
   assign core_valid     = m_valid;
   always @(posedge clk) begin
      if (core_rst) begin
         m_cnt   <= 0;
         m_valid <= 1'b0;
      end else if (!m_never && !m_valid) begin
         if (m_cnt == m_delay - 1) m_valid <= 1'b1;
         m_cnt <= m_cnt + 1;
      end
   end

   typedef struct { logic [31:0] data; logic last; } word_t;
   typedef struct { logic [31:0] cyc;  logic to;   } op_t;
   word_t wq[$];
   op_t   oq[$];

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic expect_op(input logic [255:0] res, input logic [31:0] cyc, input logic to);
      word_t w;
      op_t   o;
      for (int i = 0; i < 8; i++) begin
         w.data = res[255-32*i -: 32];
         w.last = (i == 7);
         wq.push_back(w);
      end
      o.cyc = cyc;
      o.to  = to;
      oq.push_back(o);
   endtask

   // Monitor: samples just after the negedge, i.e. the values the next posedge sees.
   initial begin
      word_t w;
      op_t   o;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (wq.size() == 0) begin
               checks++; failures++;
               $display("FAIL extra_word: got %h expected no word", bus.out_data);
            end else begin
               w = wq.pop_front();
               chk("out_data", bus.out_data, w.data);
               chk("out_last", bus.out_last, w.last);
               if (w.last) begin
                  if (oq.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL op_status: got cycles=%0d expected no operation", cycles);
                  end else begin
                     o = oq.pop_front();
                     chk("cycles", cycles, o.cyc);
                     chk("timeout", timeout, o.to);
                  end
               end
            end
         end
      end
   end

   task automatic load(input logic [255:0] sc, input logic [255:0] pt, input int nwords, input bit stall);
      int k = 0;
      while (k < nwords) begin
         @(negedge clk);
         chk("core_rst_in_load", core_rst, 1'b0);
         if (stall && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = (k < 8) ? sc[255-32*k -: 32] : pt[255-32*(k-8) -: 32];
            k++;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 32'hdead_beef;
      if (nwords == 16) begin
         #1;
         chk("start_core_rst", core_rst, 1'b1);
         chk("start_busy", busy, 1'b1);
         chk("start_in_ready", bus.in_ready, 1'b0);
         chk("core_scalar", core_scalar, sc);
         chk("core_point", core_point, pt);
         @(negedge clk);
         #1;
         chk("run_core_rst", core_rst, 1'b0);
         chk("run_busy", busy, 1'b1);
         chk("run_cycles_clr", cycles, 32'd0);
         chk("run_timeout_clr", timeout, 1'b0);
      end
   endtask

   task automatic run_op(input int hold_at);
      int acc = 0;
      int n = 0;
      logic [31:0] d;
      while (acc < 8 && n < 1000) begin
         @(negedge clk);
         n++;
         if (bus.out_valid && bus.out_ready && acc == hold_at) begin
            bus.out_ready = 1'b0;
            d = bus.out_data;
            repeat (5) begin
               @(negedge clk);
               chk("bp_hold_data", bus.out_data, d);
               chk("bp_hold_valid", bus.out_valid, 1'b1);
            end
            bus.out_ready = 1'b1;
         end
         if (bus.out_valid && bus.out_ready) acc++;
      end
      if (acc < 8) begin
         checks++; failures++;
         $display("FAIL drain_timeout: got %0d words expected 8", acc);
      end
      @(negedge clk);
      #1;
      chk("reload_in_ready", bus.in_ready, 1'b1);
      chk("reload_busy", busy, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   localparam logic [255:0] SC_A  = 256'h77076d0a7318a57d3c16c17251b26645df4c2f87ebc0992ab177fba51db92c2a;
   localparam logic [255:0] PT_A  = {8'h09, 248'h0};
   localparam logic [255:0] RES_A = 256'h8520f0098930a754748b7ddcb43ef75a0dbf3a0d26381af4eba4a98eaa9b4e6a;
   localparam logic [255:0] SC_B  = 256'h0001020304050607_08090a0b0c0d0e0f_1011121314151617_18191a1b1c1d1e1f;
   localparam logic [255:0] PT_B  = 256'hf0e1d2c3b4a59687_78695a4b3c2d1e0f_0123456789abcdef_fedcba9876543210;
   localparam logic [255:0] RES_B = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
   localparam logic [255:0] RES_C = 256'hcafef00d_0badc0de_deadbeef_a5a5a5a5_5a5a5a5a_00000001_80000000_ffffffff;

   initial begin
      int n;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = 32'd0;
      bus.out_ready = 1'b1;
      m_res = '0; m_delay = 100; m_never = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_core_rst", core_rst, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_last", bus.out_last, 1'b0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_cycles", cycles, 32'd0);
      chk("rst_core_scalar", core_scalar, 256'd0);
      chk("rst_core_point", core_point, 256'd0);
      chk("rst_core_rst_low", core_rst, 1'b0);

      // RFC 7748 vector, core answers after 100 cycles
      m_res = RES_A; m_delay = 100;
      expect_op(RES_A, 32'd100, 1'b0);
      load(SC_A, PT_A, 16, 1'b0);
      run_op(-1);

      // Back-to-back with stale valid still high, plus random input stalls
      m_res = RES_B; m_delay = 37;
      expect_op(RES_B, 32'd37, 1'b0);
      load(SC_B, PT_B, 16, 1'b1);
      run_op(-1);

      // Output backpressure on word 3
      m_res = RES_C; m_delay = 10;
      expect_op(RES_C, 32'd10, 1'b0);
      load(PT_B, SC_B, 16, 1'b0);
      run_op(3);

      // Timeout: core never answers
      m_never = 1'b1;
      expect_op(256'd0, TMO, 1'b1);
      load(SC_A, PT_B, 16, 1'b0);
      run_op(-1);
      chk("timeout_held", timeout, 1'b1);

      // Next op clears timeout (checked inside load)
      m_never = 1'b0; m_res = RES_A; m_delay = 5;
      expect_op(RES_A, 32'd5, 1'b0);
      load(SC_A, PT_A, 16, 1'b1);
      run_op(-1);

      // Reset at RUN cycle 20
      m_res = RES_B; m_delay = 100;
      load(SC_B, PT_B, 16, 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrun_core_rst", core_rst, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrun_busy", busy, 1'b0);
      chk("midrun_in_ready", bus.in_ready, 1'b1);
      chk("midrun_cycles", cycles, 32'd0);
      chk("midrun_out_valid", bus.out_valid, 1'b0);

      // Reset after 5 loaded words
      load(SC_B, PT_B, 5, 1'b0);
      rst = 1'b1;
      #1;
      chk("midload_core_rst", core_rst, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midload_core_scalar", core_scalar, 256'd0);
      chk("midload_in_ready", bus.in_ready, 1'b1);
      chk("midload_busy", busy, 1'b0);

      // Full operation after the resets
      m_res = RES_C; m_delay = 60;
      expect_op(RES_C, 32'd60, 1'b0);
      load(SC_A, PT_A, 16, 1'b0);
      run_op(-1);

      n = 0;
      while (wq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_words_left", wq.size(), 0);
      chk("scoreboard_ops_left", oq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
